ram_dma: RTL and testbench
==========================

# ram_dma

Single-port RAM initiator (DMA engine) for the interrupt pipeline. It is programmed by the CPU through a start pulse and performs block copy or block fill operations on the data RAM. It drives the RAM's `we`/`addr`/`d` inputs and samples its combinational read port `q`, then raises an interrupt request on completion. It sits between the CPU's memory-mapped control registers and a mux in front of the data RAM port; the mux is outside this block.

## Interface
- `ADDR_WIDTH`, 10: RAM word-address width; also the width of pointers and length.
- `DATA_WIDTH`, 32: RAM word width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; **asynchronous, active-low**.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill; sampled with `start`.
- `src`  in  ADDR_WIDTH  copy source base address.
- `dst`  in  ADDR_WIDTH  destination base address.
- `len`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- `fill_val`  in  DATA_WIDTH  fill pattern.
- `abort`  in  1  stop after the current word.
- `irq_ack`  in  1  clears `irq`.
- `mem_we`  out  1  RAM write enable.
- `mem_addr`  out  ADDR_WIDTH  RAM address.
- `mem_d`  out  DATA_WIDTH  RAM write data.
- `mem_q`  in  DATA_WIDTH  RAM read data, combinational from `mem_addr`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  status: the last operation ended by `abort`; held until the next accepted `start`.
- `irq`  out  1  interrupt request level.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE
  - On `start=1`: latch `mode`, `src`, `dst`, `fill_val`, and count = `len`; clear `aborted`.
  - If `len==0`, go to DONE. Otherwise go to RD for copy, or WR for fill.
- RD (copy only)
  - Drive `mem_addr=src_ptr`, `mem_we=0`.
  - Register `mem_q` into `buf` at the clock edge.
  - Go to WR.
- WR
  - Drive `mem_addr=dst_ptr`, `mem_d` = `buf` (copy) or `fill_val` (fill), `mem_we=1`.
  - At the edge: increment `src_ptr` and `dst_ptr` modulo 2^ADDR_WIDTH, and decrement count.
  - If the new count is 0, or `abort` is high this cycle, go to DONE (set `aborted` on abort).
  - Otherwise go to RD (copy) or stay in WR (fill).
- DONE: `done=1` for one cycle; set `irq`; go to IDLE.
- `start` while busy is ignored and has no side effect.
- `abort` in RD completes that word's WR first; `abort` in IDLE is ignored.
- Overlapping ranges copy in ascending address order with no hazard handling; overlap with `dst>src` replicates data, by definition.
- Outside WR: `mem_we=0`. `mem_addr` = `src_ptr` in RD, `dst_ptr` in WR, and 0 in IDLE/DONE. `mem_d` is 0 when not writing.

## Timing
- Reset values: state IDLE; all outputs 0; pointers, count and `buf` are 0.
- Reset mid-operation: the FSM returns to IDLE immediately.
  - A RAM write that was asserted stops at once; no partial-state retention.
- Latency from `start` edge to `done` high:
  - copy: 2·len+1 cycles;
  - fill: len+1 cycles;
  - `len==0`: 1 cycle.
- `done` and `irq` rise in the same cycle. A new `start` is accepted in the cycle after `done`.
- `irq` clears on the edge after `irq_ack=1`.
- If `irq_ack` and a new DONE occur in the same cycle, set wins and `irq` stays 1.
- `len=2^ADDR_WIDTH`: every word is touched once and the pointers wrap back to base.

## Configuration
- `RAM_DMA_IRQ_EN` defined: `irq`/`irq_ack` behave as above.
- Not defined: `irq` is tied to 0, `irq_ack` is ignored, and completion is signalled by `done`/`busy` only.

## Test plan
- Copy, src=0x010, dst=0x100, len=4, RAM[0x10..0x13]=A,B,C,D:
  - RAM[0x100..0x103]=A,B,C,D;
  - `done` at cycle 9 after start;
  - `mem_we` high on exactly 4 cycles.
- Fill, dst=0x3FE, len=4, fill_val=0xDEADBEEF:
  - addresses 0x3FE, 0x3FF, 0x000, 0x001 are written;
  - `done` at cycle 5.
- `len=0`: `done` one cycle after start; no `mem_we`; `irq`=1 (macro on).
- Copy len=8 with `abort` during the 3rd RD:
  - exactly 3 words are written;
  - `aborted`=1;
  - `start` pulses issued while busy are ignored.
- Pull `rst` low during WR of a fill:
  - `mem_we` drops without waiting for a clock edge;
  - `busy`/`irq`=0;
  - a later start runs normally.
- `irq_ack` asserted the same cycle as a second completion: `irq` remains 1; a later ack clears it. With the macro off, `irq` stays 0 throughout.

Source files
------------

// File: rtl/ram_dma_if.sv
// ram_dma_if: bundles the DMA control inputs, the status outputs and the RAM
// port that ram_dma drives.
//   master : the DMA engine side (drives mem_we/mem_addr/mem_d and status)
//   slave  : the CPU register block / RAM mux side
// Ports grouped here:
//   start, mode, src, dst, len, fill_val, abort, irq_ack -> control in
//   mem_we, mem_addr, mem_d                              -> RAM write/address
//   mem_q                                                -> RAM read data
//   busy, done, aborted, irq                             -> status out
interface ram_dma_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH:0]   len;
  logic [DATA_WIDTH-1:0] fill_val;
  logic                  abort;
  logic                  irq_ack;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_d;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  busy;
  logic                  done;
  logic                  aborted;
  logic                  irq;

  modport master (
    input  start, mode, src, dst, len, fill_val, abort, irq_ack, mem_q,
    output mem_we, mem_addr, mem_d, busy, done, aborted, irq
  );

  modport slave (
    output start, mode, src, dst, len, fill_val, abort, irq_ack, mem_q,
    input  mem_we, mem_addr, mem_d, busy, done, aborted, irq
  );
endinterface

// File: rtl/ram_dma.sv
// ram_dma: block copy / block fill engine for a single-port data RAM.
// A start pulse in IDLE latches the job; copy alternates RD/WR per word,
// fill writes one word per cycle; completion pulses done and raises irq.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - ram_dma_if.master (control, status and RAM port)
// Build option: define RAM_DMA_IRQ_EN to enable irq/irq_ack; otherwise irq
// is held at 0 and irq_ack is ignored.
// All outputs are registered from next-state values, so each output shows
// the value belonging to the state the FSM occupies in that cycle.
module ram_dma #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  ram_dma_if.master bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [1:0]            state_r,   nxt_state_s;
  logic                  mode_r,    nxt_mode_s;
  logic [ADDR_WIDTH-1:0] src_ptr_r, nxt_src_s;
  logic [ADDR_WIDTH-1:0] dst_ptr_r, nxt_dst_s;
  logic [ADDR_WIDTH:0]   cnt_r,     nxt_cnt_s;
  logic [DATA_WIDTH-1:0] buf_r,     nxt_buf_s;
  logic [DATA_WIDTH-1:0] fill_r,    nxt_fill_s;
  logic                  pend_r,    nxt_pend_s;     // abort seen during RD
  logic                  aborted_r, nxt_aborted_s;
  logic                  irq_r,     nxt_irq_s;
  logic                  mem_we_r,  nxt_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, nxt_addr_s;
  logic [DATA_WIDTH-1:0] mem_d_r,   nxt_d_s;
  logic                  busy_r,    nxt_busy_s;
  logic                  done_r,    nxt_done_s;

  // Next-state and datapath update for the IDLE/RD/WR/DONE sequence
  always_comb begin
    nxt_state_s   = state_r;
    nxt_mode_s    = mode_r;
    nxt_src_s     = src_ptr_r;
    nxt_dst_s     = dst_ptr_r;
    nxt_cnt_s     = cnt_r;
    nxt_buf_s     = buf_r;
    nxt_fill_s    = fill_r;
    nxt_pend_s    = pend_r;
    nxt_aborted_s = aborted_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          nxt_mode_s    = bus.mode;
          nxt_src_s     = bus.src;
          nxt_dst_s     = bus.dst;
          nxt_fill_s    = bus.fill_val;
          nxt_cnt_s     = bus.len;
          nxt_pend_s    = 1'b0;
          nxt_aborted_s = 1'b0;
          if (bus.len == CNT_ZERO) begin
            nxt_state_s = S_DONE;
          end else if (bus.mode) begin
            nxt_state_s = S_WR;
          end else begin
            nxt_state_s = S_RD;
          end
        end else begin
          nxt_state_s = S_IDLE;
        end
      end
      S_RD: begin
        nxt_buf_s   = bus.mem_q;
        nxt_state_s = S_WR;
        // The word being read is still written before stopping
        if (bus.abort) begin
          nxt_pend_s = 1'b1;
        end else begin
          nxt_pend_s = pend_r;
        end
      end
      S_WR: begin
        nxt_src_s = src_ptr_r + ADDR_ONE;
        nxt_dst_s = dst_ptr_r + ADDR_ONE;
        nxt_cnt_s = cnt_r - CNT_ONE;
        if (bus.abort || pend_r) begin
          nxt_state_s   = S_DONE;
          nxt_aborted_s = 1'b1;
        end else if (cnt_r == CNT_ONE) begin
          nxt_state_s = S_DONE;
        end else if (mode_r) begin
          nxt_state_s = S_WR;
        end else begin
          nxt_state_s = S_RD;
        end
      end
      S_DONE: begin
        nxt_state_s = S_IDLE;
      end
      default: begin
        nxt_state_s = S_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so they register cleanly
  always_comb begin
    nxt_we_s   = 1'b0;
    nxt_addr_s = ADDR_ZERO;
    nxt_d_s    = DATA_ZERO;
    case (nxt_state_s)
      S_RD: begin
        nxt_addr_s = nxt_src_s;
      end
      S_WR: begin
        nxt_we_s   = 1'b1;
        nxt_addr_s = nxt_dst_s;
        if (nxt_mode_s) begin
          nxt_d_s = nxt_fill_s;
        end else begin
          nxt_d_s = nxt_buf_s;
        end
      end
      default: begin
        nxt_we_s = 1'b0;
      end
    endcase
    nxt_busy_s = (nxt_state_s != S_IDLE);
    nxt_done_s = (nxt_state_s == S_DONE);
  end

`ifdef RAM_DMA_IRQ_EN
  // irq set on entering DONE and held through DONE so a same-cycle ack loses
  always_comb begin
    if ((nxt_state_s == S_DONE) || (state_r == S_DONE)) begin
      nxt_irq_s = 1'b1;
    end else if (bus.irq_ack) begin
      nxt_irq_s = 1'b0;
    end else begin
      nxt_irq_s = irq_r;
    end
  end
`else
  logic irq_ack_unused_s;
  assign irq_ack_unused_s = bus.irq_ack;

  // Interrupt disabled in this build
  always_comb begin
    nxt_irq_s = 1'b0;
  end
`endif

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      mode_r     <= 1'b0;
      src_ptr_r  <= ADDR_ZERO;
      dst_ptr_r  <= ADDR_ZERO;
      cnt_r      <= CNT_ZERO;
      buf_r      <= DATA_ZERO;
      fill_r     <= DATA_ZERO;
      pend_r     <= 1'b0;
      aborted_r  <= 1'b0;
      irq_r      <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= ADDR_ZERO;
      mem_d_r    <= DATA_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      mode_r     <= nxt_mode_s;
      src_ptr_r  <= nxt_src_s;
      dst_ptr_r  <= nxt_dst_s;
      cnt_r      <= nxt_cnt_s;
      buf_r      <= nxt_buf_s;
      fill_r     <= nxt_fill_s;
      pend_r     <= nxt_pend_s;
      aborted_r  <= nxt_aborted_s;
      irq_r      <= nxt_irq_s;
      mem_we_r   <= nxt_we_s;
      mem_addr_r <= nxt_addr_s;
      mem_d_r    <= nxt_d_s;
      busy_r     <= nxt_busy_s;
      done_r     <= nxt_done_s;
    end
  end

  assign bus.mem_we   = mem_we_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_d    = mem_d_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.aborted  = aborted_r;
  assign bus.irq      = irq_r;
endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: randomized self-checking bench for ram_dma. Each job is turned
// into an expected per-cycle trace (offset from the start edge) and an
// expected final RAM image by plain arithmetic; a negedge process compares
// the DUT outputs against that trace every cycle.
module tb_ram_dma;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int MAXO  = 2100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ram_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] ram     [0:DEPTH-1];
  logic [DW-1:0] mdl_ram [0:DEPTH-1];
  assign bus.mem_q = ram[bus.mem_addr];

  int cyc = 0, s_edge = -100000, n_done = 0, op_p = 0;
  bit op_ab = 1'b0, prev_ab = 1'b0, irq_m = 1'b0, chk_en = 1'b0;
  int vectors = 0, miscompares = 0, we_cnt = 0, done_off = -1, prints = 0;
  bit            e_we   [0:MAXO];
  logic [AW-1:0] e_addr [0:MAXO];
  logic [DW-1:0] e_d    [0:MAXO];

  int o;
  bit x_we, x_busy, x_done, x_ab;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_d;

  // RAM write port and irq expectation, advanced on the active edge
  always @(posedge clk) begin
    op_p = cyc - s_edge;
`ifdef RAM_DMA_IRQ_EN
    if ((op_p + 1 == n_done) || (op_p == n_done)) irq_m = 1'b1;
    else if (bus.irq_ack) irq_m = 1'b0;
`endif
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_d;
    cyc = cyc + 1;
  end

  // Per-cycle comparison of every DUT output against the expected trace
  always @(negedge clk) begin
    if (chk_en) begin
      o = cyc - s_edge;
      if (o >= 1 && o <= n_done) begin
        x_we = e_we[o]; x_addr = e_addr[o]; x_d = e_d[o];
        x_busy = 1'b1; x_done = (o == n_done);
      end else begin
        x_we = 1'b0; x_addr = '0; x_d = '0; x_busy = 1'b0; x_done = 1'b0;
      end
      if (o >= 1 && o < n_done) x_ab = 1'b0;
      else if (o >= 1) x_ab = op_ab;
      else x_ab = prev_ab;
      vectors++;
      if (bus.mem_we !== x_we || bus.mem_addr !== x_addr || bus.mem_d !== x_d ||
          bus.busy !== x_busy || bus.done !== x_done || bus.aborted !== x_ab ||
          bus.irq !== irq_m) begin
        miscompares++;
        if (prints < 20) begin
          prints++;
          $display("FAIL cycle o=%0d got/want we %b/%b addr %h/%h d %h/%h busy %b/%b done %b/%b aborted %b/%b irq %b/%b",
                   o, bus.mem_we, x_we, bus.mem_addr, x_addr, bus.mem_d, x_d, bus.busy, x_busy,
                   bus.done, x_done, bus.aborted, x_ab, bus.irq, irq_m);
        end
      end
      if (bus.mem_we) we_cnt++;
      if (bus.done) done_off = o;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic check_ram(input string nm);
    int bad = 0, first = -1;
    for (int i = 0; i < DEPTH; i++)
      if (ram[i] !== mdl_ram[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    vectors++;
    if (bad > 0) begin
      miscompares++;
      $display("FAIL %s ram[%0d] got %h want %h (%0d words differ)", nm, first,
               ram[first], mdl_ram[first], bad);
    end
  endtask

  // One job: build expected trace + RAM image, issue start, drive the job's cycles
  task automatic run_op(input bit md, input logic [AW-1:0] sr, input logic [AW-1:0] ds,
                        input logic [AW:0] ln, input logic [DW-1:0] fv,
                        input int ab_off, input int rst_off, input bit ack_done);
    int w, wa, n, lim;
    logic [AW-1:0] as, ad;
    logic [DW-1:0] dv;
    w = int'(ln);
    if (ab_off > 0) begin
      wa = md ? ab_off : (ab_off - 1) / 2 + 1;
      if (wa < w) w = wa;
    end
    n   = (ln == 0) ? 1 : (md ? w + 1 : 2 * w + 1);
    lim = (rst_off > 0) ? rst_off - 1 : w;
    for (int k = 1; k <= n; k++) begin
      e_we[k] = 1'b0; e_addr[k] = '0; e_d[k] = '0;
    end
    for (int i = 0; i < w; i++) begin
      as = sr + AW'(i);
      ad = ds + AW'(i);
      if (md) begin
        e_we[i+1] = 1'b1; e_addr[i+1] = ad; e_d[i+1] = fv;
        if (i < lim) mdl_ram[ad] = fv;
      end else begin
        dv = mdl_ram[as];
        e_addr[2*i+1] = as;
        e_we[2*i+2] = 1'b1; e_addr[2*i+2] = ad; e_d[2*i+2] = dv;
        if (i < lim) mdl_ram[ad] = dv;
      end
    end
    @(negedge clk);
    prev_ab = op_ab; op_ab = (ab_off > 0) && (ln != 0);
    s_edge = cyc; n_done = n; we_cnt = 0; done_off = -1;
    bus.start = 1'b1; bus.mode = md; bus.src = sr; bus.dst = ds; bus.len = ln;
    bus.fill_val = fv; bus.abort = 1'($urandom % 2); bus.irq_ack = ($urandom % 4 == 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (rst_off > 0 && k == rst_off) begin
        #2;
        chk_en = 1'b0; rst = 1'b0;
        #1;
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_done", bus.done, 0);
        s_edge = -100000; n_done = 0; op_ab = 1'b0; prev_ab = 1'b0; irq_m = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.irq_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1; chk_en = 1'b1;
        return;
      end
      bus.start    = (k < n) && ((k == 2) || ($urandom % 3 == 0));
      bus.mode     = 1'($urandom % 2);
      bus.src      = AW'($urandom);
      bus.dst      = AW'($urandom);
      bus.len      = (AW+1)'($urandom % 1025);
      bus.fill_val = $urandom;
      bus.abort    = (k == ab_off);
      bus.irq_ack  = (ack_done && k == n) ? 1'b1 : ($urandom % 4 == 0);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] v0;
    int fn, ab;
    logic [AW:0] ln;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    bus.fill_val = '0; bus.abort = 1'b0; bus.irq_ack = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom; ram[i] = v; mdl_ram[i] = v;
    end
    #1;
    chk("reset_mem_we", bus.mem_we, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_mem_d", bus.mem_d, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_aborted", bus.aborted, 0);
    chk("reset_irq", bus.irq, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1; chk_en = 1'b1;

    // Copy of four known words
    for (int i = 0; i < 4; i++) begin
      ram[16+i] = 32'hA0000001 + i; mdl_ram[16+i] = 32'hA0000001 + i;
    end
    run_op(1'b0, 10'h010, 10'h100, 11'd4, 32'h0, 0, 0, 1'b0);
    #1;
    chk("copy4_done_cycle", done_off, 9);
    chk("copy4_we_cycles", we_cnt, 4);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("copy4_dst_word", ram[256+i], 32'hA0000001 + i);
    check_ram("copy4_ram");

    // Fill crossing the top of memory
    run_op(1'b1, 10'h000, 10'h3FE, 11'd4, 32'hDEADBEEF, 0, 0, 1'b0);
    #1;
    chk("fill4_done_cycle", done_off, 5);
    chk("fill4_we_cycles", we_cnt, 4);
    @(negedge clk);
    chk("fill4_3fe", ram[10'h3FE], 32'hDEADBEEF);
    chk("fill4_3ff", ram[10'h3FF], 32'hDEADBEEF);
    chk("fill4_000", ram[10'h000], 32'hDEADBEEF);
    chk("fill4_001", ram[10'h001], 32'hDEADBEEF);
    check_ram("fill4_ram");

    // Zero-length job
    run_op(1'b0, 10'h020, 10'h030, 11'd0, 32'h0, 0, 0, 1'b0);
    #1;
    chk("len0_done_cycle", done_off, 1);
    chk("len0_we_cycles", we_cnt, 0);
`ifdef RAM_DMA_IRQ_EN
    chk("len0_irq", bus.irq, 1);
`else
    chk("len0_irq", bus.irq, 0);
`endif

    // Copy of 8 aborted in the third RD (offset 5)
    run_op(1'b0, 10'h040, 10'h080, 11'd8, 32'h0, 5, 0, 1'b0);
    #1;
    chk("abort_we_cycles", we_cnt, 3);
    chk("abort_done_cycle", done_off, 7);
    chk("abort_flag", bus.aborted, 1);
    @(negedge clk);
    check_ram("abort_ram");

    // Reset during a fill's third WR, then a normal overlapping copy
    run_op(1'b1, 10'h000, 10'h200, 11'd6, 32'h5A5A1234, 0, 3, 1'b0);
    @(negedge clk);
    check_ram("reset_fill_ram");
    v0 = mdl_ram[10'h300];
    run_op(1'b0, 10'h300, 10'h301, 11'd5, 32'h0, 0, 0, 1'b0);
    @(negedge clk);
    chk("overlap_replicate", ram[10'h305], v0);
    check_ram("overlap_ram");

    // Ack coinciding with DONE, then a later ack
    run_op(1'b1, 10'h000, 10'h123, 11'd2, 32'h01234567, 0, 0, 1'b1);
    @(negedge clk);
    bus.irq_ack = 1'b0;
    #1;
`ifdef RAM_DMA_IRQ_EN
    chk("ack_at_done_irq", bus.irq, 1);
`else
    chk("ack_at_done_irq", bus.irq, 0);
`endif
    @(negedge clk); bus.irq_ack = 1'b1;
    @(negedge clk); bus.irq_ack = 1'b0;
    #1;
    chk("ack_clears_irq", bus.irq, 0);

    // Full-size jobs: every word touched, pointers wrap
    run_op(1'b1, 10'h000, 10'h155, 11'd1024, 32'hCAFEF00D, 0, 0, 1'b0);
    @(negedge clk);
    check_ram("full_fill_ram");
    run_op(1'b0, 10'h000, 10'h200, 11'd1024, 32'h0, 0, 0, 1'b0);
    @(negedge clk);
    check_ram("full_copy_ram");

    // Random jobs
    repeat (40) begin
      bit md;
      md = 1'($urandom % 2);
      ln = ($urandom % 8 == 0) ? (AW+1)'($urandom % 1025) : (AW+1)'($urandom % 20);
      fn = md ? int'(ln) + 1 : 2 * int'(ln) + 1;
      ab = (ln != 0 && $urandom % 4 == 0) ? $urandom_range(1, fn - 1) : 0;
      run_op(md, AW'($urandom), AW'($urandom), ln, $urandom, ab, 0, 1'($urandom % 2));
      repeat ($urandom % 3) begin
        @(negedge clk);
        bus.irq_ack = ($urandom % 3 == 0);
        bus.abort = 1'($urandom % 2);
      end
      @(negedge clk);
      check_ram("random_ram");
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
